// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared types and constants for the nibble-serial CLA adder.
//                state_t : FSM encoding (IDLE / RUN / DONE)
//                NIB_W   : native width of the carry-lookahead slice
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_serial_adder_cla.sv
`default_nettype none
// ============================================================================
//  Module      : CarryLookAheadAdder
//  Description : Purely combinational 4-bit carry-lookahead adder.
//                A, B  : 4-bit addends
//                Cin   : carry into bit 0
//                S     : 4-bit sum
//                Cout  : carry out of bit 3
//  Revision    : 1.0 - initial release
// ============================================================================
module CarryLookAheadAdder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = A ^ B;
    assign w_g = A & B;

    // Every carry is expanded directly from generate/propagate terms so no
    // carry ripples through another.
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign S    = w_p ^ w_c[3:0];
    assign Cout = w_c[4];

endmodule : CarryLookAheadAdder
`default_nettype wire

// File: rtl/cla_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_serial_adder
//  Description : WIDTH-bit adder computed one nibble per clock through a
//                single shared 4-bit carry-lookahead slice, LS nibble first.
//                clk, rst_n      : clock, synchronous active-low reset
//                in_valid/ready  : operand handshake (A, B, Cin)
//                out_valid/ready : result handshake (S, Cout, Ovf)
//                {Cout,S} = A + B + Cin ; Ovf = two's-complement overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIB - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [NIB_W-1:0] w_a_nibs [NIB];
    logic [NIB_W-1:0] w_b_nibs [NIB];
    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_cla_s;
    logic             w_cla_cout;

    // ------------------------------------------------------------------
    // Nibble selection for the shared CLA slice
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NIB; n++) begin : g_nib
        assign w_a_nibs[n] = r_a[n*NIB_W +: NIB_W];
        assign w_b_nibs[n] = r_b[n*NIB_W +: NIB_W];
    end

    assign w_a_nib = w_a_nibs[r_idx];
    assign w_b_nib = w_b_nibs[r_idx];

    CarryLookAheadAdder u_cla (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Cin  (r_carry),
        .S    (w_cla_s),
        .Cout (w_cla_cout)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_run    = (r_state == RUN);
    assign w_last   = (r_idx == c_last_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture; contents are only consumed after an accept, so no
    // reset is needed here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= A;
            r_b <= B;
        end
    end

    // ------------------------------------------------------------------
    // Nibble datapath: carry chain, index and sum write-back
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_carry <= Cin;
            r_s     <= '0;
        end else if (w_run) begin
            for (int n = 0; n < NIB; n++) begin
                if (r_idx == IDX_W'(n)) begin
                    r_s[n*NIB_W +: NIB_W] <= w_cla_s;
                end
            end
            r_carry <= w_cla_cout;
            if (w_last) begin
                // Index parks at 0 so it never exceeds NIB-1.
                r_idx  <= '0;
                r_cout <= w_cla_cout;
                // The top sum bit is produced by this final slice.
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_cla_s[NIB_W-1] != r_a[WIDTH-1]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign S         = r_s;
    assign Cout      = r_cout;
    assign Ovf       = r_ovf;

endmodule : cla_serial_adder
`default_nettype wire

// File: tb/tb_cla_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_serial_adder
//  Description : Directed self-checking bench for cla_serial_adder (WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    int n_checks = 0;
    int n_errors = 0;

    cla_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with out_ready held high; checks latency and result.
    task automatic do_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] es, input logic ec,
                          input logic eo);
        int lat;
        A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NIB));
        check({tag, "_S"},    32'(S),    32'(es));
        check({tag, "_Cout"}, 32'(Cout), 32'(ec));
        check({tag, "_Ovf"},  32'(Ovf),  32'(eo));
        tick();
        check({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_S_hold"},      32'(S),         32'(es));
    endtask

    // Independent reference: whole-word addition.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        logic [16:0] t;
        logic        o;
        t = 17'(a) + 17'(b) + 17'(cin);
        o = (a[15] == b[15]) && (t[15] != a[15]);
        return {o, t};
    endfunction

    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    int          acc_cyc [3];

    initial begin
        int cyc;
        int j;
        int r;
        logic [17:0] m;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S",         32'(S),         32'd0);
        check("rst_Cout",      32'(Cout),      32'd0);
        check("rst_Ovf",       32'(Ovf),       32'd0);

        // Basic, full carry chain, overflow and wrap cases
        do_add("t1",   16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        do_add("t2",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_add("t3a",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_add("t3b",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_add("t3c",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_add("t3d",  16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

        // Backpressure: result must hold while new operands wait
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        A = 16'hAAAA; B = 16'h1111;
        r = 0;
        while (!out_valid && r < 20) begin
            tick();
            r++;
        end
        check("bp_latency", 32'(r), 32'(NIB));
        for (int k = 0; k < 5; k++) begin
            check("bp_S",         32'(S),         32'h5555);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        check("bp_hs_S_kept",   32'(S),        32'h5555);
        tick();
        in_valid = 1'b0;
        r = 0;
        while (!out_valid && r < 20) begin
            tick();
            r++;
        end
        check("bp2_latency", 32'(r), 32'(NIB));
        check("bp2_S",       32'(S), 32'hBBBB);
        tick();

        // Reset in the middle of RUN
        A = 16'h0F0F; B = 16'h0101; Cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_S",         32'(S),         32'd0);
        check("mr_Cout",      32'(Cout),      32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd1);
        do_add("mr_next", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Back-to-back streaming
        va[0] = 16'hA5A5; vb[0] = 16'h5A5A; vc[0] = 1'b1;
        va[1] = 16'h4000; vb[1] = 16'h4000; vc[1] = 1'b0;
        va[2] = 16'h1357; vb[2] = 16'h2468; vc[2] = 1'b1;
        out_ready = 1'b1;
        cyc = 0; j = 0; r = 0;
        while (r < 3 && cyc < 100) begin
            if (in_ready && j < 3) begin
                A = va[j]; B = vb[j]; Cin = vc[j]; in_valid = 1'b1;
                acc_cyc[j] = cyc;
                j++;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                m = ref_add(va[r], vb[r], vc[r]);
                check("b2b_S",    32'(S),    32'(m[15:0]));
                check("b2b_Cout", 32'(Cout), 32'(m[16]));
                check("b2b_Ovf",  32'(Ovf),  32'(m[17]));
                r++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_results", 32'(r), 32'd3);
        check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(NIB + 2));
        check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(NIB + 2));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cla_serial_adder
`default_nettype wire
